// File: rtl/imem_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
// A request holds its address until the memory acknowledges it.
interface imem_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word fetches, holds one instruction for the
// controller, and redirects on taken branches without abandoning an open request.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  imem_if.master      imem,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, DRAIN} state_t;

  localparam logic [31:0] RESET_WORD = {RESET_PC[31:2], 2'b00};

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] instr_n, pc_n;
  logic [31:0] target;

  assign target = {branch_target[31:2], 2'b00};

  // NOTE: every next-value is defaulted to its current value first, so no path
  // through the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = addr_q;
    instr_n    = instr;
    pc_n       = pc;
    unique case (state)
      IDLE: begin
        state_n = FETCH;
        addr_n  = fetch_pc;
      end
      FETCH: begin
        if (branch_taken) begin
          fetch_pc_n = target;
          if (imem.ack) begin
            addr_n  = target;
            state_n = FETCH;
          end else begin
            state_n = DRAIN;
          end
        end else if (imem.ack) begin
          instr_n    = imem.rdata;
          pc_n       = addr_q;
          fetch_pc_n = addr_q + 32'd4;
          state_n    = VALID;
        end
      end
      VALID: begin
        if (branch_taken) begin
          fetch_pc_n = target;
          addr_n     = target;
          state_n    = FETCH;
        end else if (!stall) begin
          addr_n  = fetch_pc;
          state_n = FETCH;
        end
      end
      DRAIN: begin
        // A redirect arriving while draining replaces the pending one.
        if (branch_taken) fetch_pc_n = target;
        if (imem.ack) begin
          addr_n  = branch_taken ? target : fetch_pc;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_WORD;
      addr_q   <= RESET_WORD;
      instr    <= 32'h0;
      pc       <= RESET_WORD;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      addr_q   <= addr_n;
      instr    <= instr_n;
      pc       <= pc_n;
    end
  end

  // Request and valid are masked by reset so a reset drops them in the same cycle.
  assign imem.req    = !reset && (state == FETCH || state == DRAIN);
  assign imem.addr   = addr_q;
  assign instr_valid = !reset && (state == VALID);

  assign op       = instr[31:26];
  assign func     = instr[5:0];
  assign pc_plus4 = pc + 32'd4;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first instruction address after reset.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word address of outstanding request, bits [1:0] always 00.
REQ-006 imem_ack  input  1  memory completion; imem_rdata valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 stall  input  1  decode/execute not accepting; hold the presented instruction.
REQ-009 branch_taken  input  1  redirect request from datapath (Branch and zero).
REQ-010 branch_target  input  32  redirect address.
REQ-011 instr_valid  output  1  instr/op/func/pc are valid for the controller.
REQ-012 instr  output  32  held instruction register.
REQ-013 op  output  6  instr[31:26], to the controller op input.
REQ-014 func  output  6  instr[5:0], to the controller func input.
REQ-015 pc  output  32  address of the held instruction.
REQ-016 pc_plus4  output  32  pc + 4, modulo 2^32.

Function
REQ-017 States SHALL be IDLE, FETCH, VALID, DRAIN; imem_req SHALL be 1 exactly in FETCH and DRAIN.
REQ-018 IDLE SHALL go to FETCH unconditionally on the next cycle, loading imem_addr from fetch_pc.
REQ-019 In FETCH/DRAIN, imem_addr SHALL stay constant until imem_ack; requests are never abandoned.
REQ-020 FETCH with imem_ack and no branch_taken: instr<=imem_rdata, pc<=imem_addr, instr_valid<=1, fetch_pc<=imem_addr+4, go to VALID.
REQ-021 VALID with stall=1: all outputs held unchanged.
REQ-022 VALID with stall=0: instruction consumed that cycle; instr_valid<=0, go to FETCH with imem_addr<=fetch_pc.
REQ-023 branch_taken SHALL be honoured in FETCH, VALID, DRAIN; ignored in IDLE and during reset.
REQ-024 branch target SHALL be branch_target with bits [1:0] forced to 00.
REQ-025 Branch in VALID (stall irrelevant, branch wins): instr_valid<=0, go to FETCH with imem_addr<=target.
REQ-026 Branch in FETCH with imem_ack the same cycle: returned data discarded, instr_valid stays 0, go to FETCH with imem_addr<=target.
REQ-027 Branch in FETCH without imem_ack: fetch_pc<=target, go to DRAIN keeping imem_addr.
REQ-028 DRAIN: on imem_ack discard data, go to FETCH with imem_addr<=fetch_pc; a new branch in DRAIN overwrites fetch_pc (latest wins).
REQ-029 Address increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-030 op, func, pc_plus4 SHALL be combinational from instr and pc; instr/pc change only on REQ-020.
REQ-031 Throughput: at most one instruction per 2 cycles with zero-wait memory.

Reset
REQ-032 While reset=1: state=IDLE, fetch_pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, instr_valid=0, instr=0, pc=RESET_PC.
REQ-033 Reset mid-request SHALL drop the request immediately; any imem_ack during reset is ignored.
REQ-034 First imem_req=1 SHALL occur on the second cycle after reset deasserts, with imem_addr=RESET_PC.

Verification
REQ-035 Zero-wait memory returning 0x8C0A0004 at 0x0 -> instr_valid=1, op=6'h23, func=6'h04, pc=0, pc_plus4=4; next request at 0x4.
REQ-036 stall=1 for 5 cycles in VALID -> instr, pc, instr_valid constant; no imem_req; stall release -> request at pc+4.
REQ-037 Branch to 0x0000_0103 in VALID with stall=1 -> instr_valid=0 next cycle, request at 0x0000_0100.
REQ-038 Branch to 0x40 in FETCH with ack delayed 3 cycles -> addr held 3 cycles, data discarded, next request at 0x40, no instr_valid for discarded word.
REQ-039 RESET_PC=32'hFFFF_FFFC, one fetch -> pc=FFFF_FFFC, pc_plus4=0, next request at 0x0.
REQ-040 Reset asserted with imem_req=1 and pending ack -> imem_req=0 immediately, outputs at reset values, restart at RESET_PC.
